// File: rtl/conbus_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conbus_rr_arb : round-robin Wishbone conbus arbiter with bus watchdog     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module conbus_rr_arb #(
  parameter int N_MASTERS = 7,
  parameter int TO_W      = 10,
  parameter int TIMEOUT   = 1000,
  localparam int ID_W     = $clog2(N_MASTERS)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 ack,
  output logic [N_MASTERS-1:0] gnt,
  output logic                 gnt_valid,
  output logic [ID_W-1:0]      gnt_id,
  output logic [N_MASTERS-1:0] err,
  output logic [7:0]           to_count
);

  localparam int            C_PAD_W    = 2 ** ID_W;
  localparam logic [TO_W-1:0] C_TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] C_LAST_INIT = ID_W'(N_MASTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t                 r_state;
  logic [N_MASTERS-1:0]   r_gnt;
  logic [N_MASTERS-1:0]   r_err;
  logic [ID_W-1:0]        r_gnt_id;
  logic [ID_W-1:0]        r_last_owner;
  logic                   r_gnt_valid;
  logic [7:0]             r_to_count;
  logic [TO_W-1:0]        r_wdog;

  logic                   w_win_any;
  logic [ID_W-1:0]        w_win_id;
  logic [N_MASTERS-1:0]   w_win_oh;
  logic [C_PAD_W-1:0]     w_req_pad;
  logic                   w_owner_req;
  logic                   w_wdog_hit;

  // Scan from the highest offset down so the nearest requester after
  // last_owner is the one left standing.
  always_comb begin
    int idx;
    idx       = 0;
    w_win_any = 1'b0;
    w_win_id  = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      idx = (int'(r_last_owner) + k) % N_MASTERS;
      if (req[idx]) begin
        w_win_any = 1'b1;
        w_win_id  = ID_W'(idx);
      end
    end
  end

  assign w_win_oh    = {{(N_MASTERS-1){1'b0}}, 1'b1} << w_win_id;
  assign w_req_pad   = C_PAD_W'(req);
  assign w_owner_req = w_req_pad[r_last_owner];
  // An ACK or a release on the threshold cycle takes precedence over the abort.
  assign w_wdog_hit  = (TIMEOUT != 0) && (r_wdog == C_TO_LAST) && !ack && w_owner_req;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_err        <= '0;
      r_gnt_id     <= '0;
      r_gnt_valid  <= 1'b0;
      r_to_count   <= '0;
      r_wdog       <= '0;
      r_last_owner <= C_LAST_INIT;
    end else begin
      r_err <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_any) begin
            r_gnt        <= w_win_oh;
            r_gnt_id     <= w_win_id;
            r_gnt_valid  <= 1'b1;
            r_last_owner <= w_win_id;
            r_wdog       <= '0;
            r_state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_owner_req) begin
            if (w_win_any) begin
              r_gnt        <= w_win_oh;
              r_gnt_id     <= w_win_id;
              r_gnt_valid  <= 1'b1;
              r_last_owner <= w_win_id;
              r_wdog       <= '0;
            end else begin
              r_gnt       <= '0;
              r_gnt_id    <= '0;
              r_gnt_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end else if (w_wdog_hit) begin
            r_err       <= r_gnt;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            if (r_to_count != 8'hFF) r_to_count <= r_to_count + 8'd1;
            r_state     <= ST_ABORT;
          end else if (ack) begin
            r_wdog <= '0;
          end else if (r_wdog != {TO_W{1'b1}}) begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_ABORT: begin
          // last_owner still names the aborted master, so the next search skips it.
          if (!w_owner_req) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign err       = r_err;
  assign to_count  = r_to_count;

endmodule
`default_nettype wire

// File: tb/tb_conbus_rr_arb.sv
`default_nettype none
// tb_conbus_rr_arb : scenario tests for the round-robin conbus arbiter (TIMEOUT=8).
module tb_conbus_rr_arb;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [6:0] req;
  logic       ack;
  logic [6:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic [6:0] err;
  logic [7:0] to_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  conbus_rr_arb #(.N_MASTERS(7), .TO_W(10), .TIMEOUT(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req      (req),
    .ack      (ack),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .err      (err),
    .to_count (to_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    req = '0; ack = 1'b0; sys_rst_n = 1'b0;
    step(); step();
    sys_rst_n = 1'b1;
  endtask

  // Pops the next expected owner and checks gnt/gnt_id/gnt_valid against it.
  task automatic pop_and_check(input string name);
    int e;
    logic [6:0] e_oh;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++; $display("FAIL %s: scoreboard empty, gnt=%h", name, gnt);
    end else begin
      e = exp_q.pop_front();
      e_oh = 7'b1 << e;
      if (gnt !== e_oh || gnt_id !== 3'(e) || gnt_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL %s: gnt=%h id=%0d valid=%b expected gnt=%h id=%0d valid=1", name, gnt, gnt_id, gnt_valid, e_oh, e);
      end
    end
  endtask

  task automatic test_reset();
    req = 7'h7F; ack = 1'b0; sys_rst_n = 1'b0;
    step(); step();
    n_checks++;
    if (gnt !== 7'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0 || err !== 7'h00 || to_count !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_state: gnt=%h valid=%b id=%0d err=%h to=%0d expected all zero", gnt, gnt_valid, gnt_id, err, to_count);
    end
    sys_rst_n = 1'b1;
    exp_q.push_back(0);
    step();
    pop_and_check("reset_first_grant");
    req = '0;
    step();
    n_checks++;
    if (gnt !== 7'h00 || gnt_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_release_idle: gnt=%h valid=%b expected 00/0", gnt, gnt_valid);
    end
  endtask

  task automatic test_round_robin();
    int e;
    int waited;
    apply_reset();
    req = 7'h13;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(4);
    end
    for (int i = 0; i < 6; i++) begin
      waited = 0;
      while (gnt_valid !== 1'b1 && waited < 20) begin step(); waited++; end
      if (waited >= 20) begin
        n_checks++; n_errors++; $display("FAIL rr_wait: no grant within 20 cycles (gnt=%h)", gnt);
      end
      e = (exp_q.size() != 0) ? exp_q[0] : 0;
      pop_and_check("rr_order");
      step(); step();
      req[e] = 1'b0;
      step();
      n_checks++;
      if (gnt_valid !== 1'b1 || gnt[e] !== 1'b0) begin
        n_errors++; $display("FAIL rr_handover: gnt=%h valid=%b expected new owner, no gap", gnt, gnt_valid);
      end
      req[e] = 1'b1;
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req = 7'h04;
    exp_q.push_back(2);
    step();
    pop_and_check("b2b_first");
    req = 7'h24;
    step(); step();
    exp_q.push_back(2);
    pop_and_check("b2b_hold");
    req = 7'h20;
    exp_q.push_back(5);
    step();
    pop_and_check("b2b_no_gap");
    req = '0;
    step(); step();
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 7'h08;
    exp_q.push_back(3);
    step();
    pop_and_check("to_grant");
    req = 7'h0A;
    for (int i = 1; i < 8; i++) begin
      step();
      n_checks++;
      if (err !== 7'h00 || gnt !== 7'h08) begin
        n_errors++; $display("FAIL to_hold: cycle %0d err=%h gnt=%h expected 00/08", i, err, gnt);
      end
    end
    step();
    n_checks++;
    if (err !== 7'h08 || gnt !== 7'h00 || to_count !== 8'd1) begin
      n_errors++; $display("FAIL to_abort: err=%h gnt=%h to=%0d expected 08/00/1", err, gnt, to_count);
    end
    step(); step(); step();
    n_checks++;
    if (err !== 7'h00 || gnt !== 7'h00 || to_count !== 8'd1) begin
      n_errors++; $display("FAIL to_abort_hold: err=%h gnt=%h to=%0d expected 00/00/1", err, gnt, to_count);
    end
    req = 7'h02;
    step();
    n_checks++;
    if (gnt !== 7'h00) begin
      n_errors++; $display("FAIL to_idle: gnt=%h expected 00", gnt);
    end
    exp_q.push_back(1);
    step();
    pop_and_check("to_next_master");
    req = '0;
    step(); step();
  endtask

  task automatic test_ack_at_threshold();
    apply_reset();
    req = 7'h08;
    exp_q.push_back(3);
    step();
    pop_and_check("ack_grant");
    for (int i = 1; i < 8; i++) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_checks++;
    if (err !== 7'h00 || gnt !== 7'h08 || to_count !== 8'd0) begin
      n_errors++; $display("FAIL ack_wins: err=%h gnt=%h to=%0d expected 00/08/0", err, gnt, to_count);
    end
    for (int i = 1; i < 8; i++) step();
    n_checks++;
    if (err !== 7'h00 || gnt !== 7'h08) begin
      n_errors++; $display("FAIL ack_restart_early: err=%h gnt=%h expected 00/08", err, gnt);
    end
    step();
    n_checks++;
    if (err !== 7'h08 || gnt !== 7'h00 || to_count !== 8'd1) begin
      n_errors++; $display("FAIL ack_restart_abort: err=%h gnt=%h to=%0d expected 08/00/1", err, gnt, to_count);
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_reset_mid_transfer();
    apply_reset();
    req = 7'h40;
    step();
    for (int i = 0; i < 8; i++) step();
    req = 7'h00;
    step();
    req = 7'h40;
    exp_q.push_back(6);
    step();
    pop_and_check("rst_mid_grant");
    n_checks++;
    if (to_count !== 8'd1) begin
      n_errors++; $display("FAIL rst_mid_precount: to=%0d expected 1", to_count);
    end
    for (int i = 1; i < 8; i++) step();
    req = 7'h7F;
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 7'h00 || gnt_valid !== 1'b0 || err !== 7'h00 || to_count !== 8'd0) begin
      n_errors++; $display("FAIL rst_mid_async: gnt=%h valid=%b err=%h to=%0d expected all zero", gnt, gnt_valid, err, to_count);
    end
    step(); step();
    n_checks++;
    if (gnt !== 7'h00 || err !== 7'h00) begin
      n_errors++; $display("FAIL rst_mid_hold: gnt=%h err=%h expected 00/00", gnt, err);
    end
    sys_rst_n = 1'b1;
    req = 7'h41;
    exp_q.push_back(0);
    step();
    pop_and_check("rst_mid_restart");
    req = '0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_ack_at_threshold();
    test_reset_mid_transfer();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
